usrt_tx_serializer: RTL and testbench

- Transmit stage of the USRT, fed by the core's 50 MHz clock.
- Accepts parallel bytes over a valid/ready handshake and serializes each one as a start bit, DATA_W data bits (LSB first), an optional parity bit and a stop bit.
- Drives a gated serial clock alongside the data. It replaces the low-rate derived clocks with an internal bit timer, so the whole stage stays on one clock domain.
- Output pins connect directly to the link; the downstream USRT receiver samples on usrt_clk rising edges.

---
 rtl/usrt_pkg.sv | 19 +
 rtl/usrt_bit_timer.sv | 54 +++++
 rtl/usrt_tx_serializer.sv | 143 ++++++++++++++
 tb/tb_usrt_tx_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame state encoding, default bit divider for the
// 50 MHz core clock, and the idle levels of the link pins.
package usrt_pkg;

  // 50 MHz / 10e6 gives 5 bit/s, slow enough to watch on LEDs
  localparam int unsigned USRT_CLK_DIV_50M = 10_000_000;

  localparam logic USRT_IDLE_DATA = 1'b1;
  localparam logic USRT_IDLE_CLK  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } usrt_state_e;

endpackage

// File: rtl/usrt_bit_timer.sv
// Bit timer for the USRT: counts 0..CLK_DIV-1 while run is high and produces
// the serial clock phase plus end-of-bit strobes.
//   clk_50Mhz  in   core clock
//   rst_n      in   async active-low reset
//   run        in   count while high, hold at 0 while low
//   usrt_clk   out  registered bit clock: low for the first half of each bit
//   bit_end_c  out  combinational, high on the last count of a bit
//   pre_end_c  out  combinational, high one count before bit_end_c
module usrt_bit_timer
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV = USRT_CLK_DIV_50M
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic run,
  output logic usrt_clk,
  output logic bit_end_c,
  output logic pre_end_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next count and the phase that count will present, so usrt_clk is a flop
  always_comb begin
    cnt_d     = '0;
    phase_d   = USRT_IDLE_CLK;
    bit_end_c = 1'b0;
    pre_end_c = 1'b0;
    if (run) begin
      bit_end_c = (cnt_q == CNT_W'(CLK_DIV - 1));
      pre_end_c = (cnt_q == CNT_W'(CLK_DIV - 2));
      cnt_d     = bit_end_c ? '0 : cnt_q + CNT_W'(1);
      phase_d   = (cnt_d >= CNT_W'(HALF));
    end
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= USRT_IDLE_CLK;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign usrt_clk = phase_q;

endmodule

// File: rtl/usrt_tx_serializer.sv
// USRT transmit serializer: accepts a word over valid/ready and sends
// start, DATA_W data bits LSB first, optional parity, stop, with a gated
// bit clock. Single clock domain; all outputs are flops.
//   clk_50Mhz   in   core clock
//   rst_n       in   async active-low reset
//   tx_data     in   word to send, sampled on the accept edge only
//   tx_valid    in   upstream has data
//   tx_ready    out  can accept (accept = tx_valid & tx_ready at clock edge)
//   usrt_clk    out  serial bit clock, low when idle
//   usrt_data   out  serial data, high when idle
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse on the last cycle of the stop bit
module usrt_tx_serializer
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV    = USRT_CLK_DIV_50M,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk_50Mhz,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              usrt_clk,
  output logic              usrt_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  usrt_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_ready_q, tx_ready_d;
  logic              usrt_data_q, usrt_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic timer_run;
  logic bit_end_c;
  logic pre_end_c;

  assign timer_run = (state_q != ST_IDLE);

  usrt_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk_50Mhz(clk_50Mhz),
    .rst_n    (rst_n),
    .run      (timer_run),
    .usrt_clk (usrt_clk),
    .bit_end_c(bit_end_c),
    .pre_end_c(pre_end_c)
  );

  // Frame sequencing; outputs are decoded from the next state so they land
  // in flops and change together with the state (i.e. at timer count 0)
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    par_d        = par_q;
    tx_ready_d   = 1'b0;
    busy_d       = 1'b0;
    usrt_data_d  = USRT_IDLE_DATA;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_ready_d   = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    // pre_end lead makes the registered pulse sit on the final stop count
    frame_done_d = (state_q == ST_STOP) && pre_end_c;

    unique case (state_d)
      ST_START:  usrt_data_d = 1'b0;
      ST_DATA:   usrt_data_d = shift_d[0];
      ST_PARITY: usrt_data_d = par_d;
      default:   usrt_data_d = USRT_IDLE_DATA;
    endcase
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      par_q        <= 1'b0;
      tx_ready_q   <= 1'b0;
      usrt_data_q  <= USRT_IDLE_DATA;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      par_q        <= par_d;
      tx_ready_q   <= tx_ready_d;
      usrt_data_q  <= usrt_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign usrt_data  = usrt_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_usrt_tx_serializer.sv
// Bench for usrt_tx_serializer: three instances (no parity, even, odd)
// share one stimulus stream; a frame-level model predicts every output.
module tb_usrt_tx_serializer;

  localparam int CD = 4;
  localparam int DW = 8;
  localparam bit PEN  [3] = '{1'b0, 1'b1, 1'b1};
  localparam bit PODD [3] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] rdy, ucl, udt, bsy, fdn;

  always #5 clk = ~clk;

  usrt_tx_serializer #(.CLK_DIV(CD), .DATA_W(DW), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk_50Mhz(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[0]), .usrt_clk(ucl[0]), .usrt_data(udt[0]), .busy(bsy[0]),
    .frame_done(fdn[0]));
  usrt_tx_serializer #(.CLK_DIV(CD), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk_50Mhz(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[1]), .usrt_clk(ucl[1]), .usrt_data(udt[1]), .busy(bsy[1]),
    .frame_done(fdn[1]));
  usrt_tx_serializer #(.CLK_DIV(CD), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk_50Mhz(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[2]), .usrt_clk(ucl[2]), .usrt_data(udt[2]), .busy(bsy[2]),
    .frame_done(fdn[2]));

  // Model: m_k is the 1-based cycle number inside the current frame
  bit         m_act [3];
  bit         m_rdy [3];
  int         m_k   [3];
  logic [7:0] m_dat [3];

  function automatic int flen(int i);
    return (DW + 2 + int'(PEN[i])) * CD;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_rdy[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (m_act[i]) begin
        if (m_k[i] == flen(i)) begin
          m_act[i] <= 1'b0;
          m_rdy[i] <= 1'b1;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end else if (m_rdy[i] && tx_valid) begin
        m_act[i] <= 1'b1;
        m_rdy[i] <= 1'b0;
        m_k[i]   <= 1;
        m_dat[i] <= tx_data;
      end else begin
        m_rdy[i] <= 1'b1;
      end
    end
  end

  function automatic logic e_data(int i);
    int b;
    logic [7:0] d;
    if (!m_act[i]) return 1'b1;
    b = (m_k[i] - 1) / CD;
    d = m_dat[i];
    if (b == 0) return 1'b0;
    if (b <= DW) return d[3'(b - 1)];
    if (PEN[i] && b == DW + 1) return (^d) ^ PODD[i];
    return 1'b1;
  endfunction

  function automatic logic e_clk(int i);
    return m_act[i] && (((m_k[i] - 1) % CD) >= CD / 2);
  endfunction

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input int i, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[u%0d] t=%0t got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  // Advance one cycle and compare every output of every instance
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      chk("tx_ready",   i, rdy[i], m_rdy[i]);
      chk("usrt_clk",   i, ucl[i], e_clk(i));
      chk("usrt_data",  i, udt[i], e_data(i));
      chk("busy",       i, bsy[i], m_act[i]);
      chk("frame_done", i, fdn[i], m_act[i] && (m_k[i] == flen(i)));
    end
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (rdy != 3'b111 && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", 0, &rdy, 1'b1);
  endtask

  // Present d for exactly one accept edge; returns at negedge of cycle 1
  task automatic send(input logic [7:0] d);
    wait_all_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  logic lit_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    tick();
    chk("rst_ready", 0, rdy[0], 1'b0);
    chk("rst_data",  0, udt[0], 1'b1);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 0, rdy[0], 1'b1);

    // 0xA5: literal bit pattern, 40/44-cycle frames
    send(8'hA5);
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) tick();
      if ((k - 1) % CD == 2 && k <= 40) chk("a5_bit", 0, udt[0], lit_a5[(k - 1) / CD]);
      if (k == 39) chk("a5_fd_early", 0, fdn[0], 1'b0);
      if (k == 39) chk("a5_even_par", 1, udt[1], 1'b0);
      if (k == 40) chk("a5_fd", 0, fdn[0], 1'b1);
      if (k == 40) chk("a5_rdy_low", 0, rdy[0], 1'b0);
      if (k == 41) chk("a5_rdy_back", 0, rdy[0], 1'b1);
      if (k == 43) chk("a5_p_stop", 1, udt[1], 1'b1);
      if (k == 44) chk("a5_p_fd", 1, fdn[1], 1'b1);
      if (k == 45) chk("a5_p_rdy", 1, rdy[1], 1'b1);
    end

    // 0x01: parity bit differs between even and odd instances
    send(8'h01);
    for (int k = 2; k <= 39; k++) tick();
    chk("01_even_par", 1, udt[1], 1'b1);
    chk("01_odd_par",  2, udt[2], 1'b0);

    // Held valid: 0x3C then 0xC3 back to back with one idle cycle
    wait_all_ready();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tick();
    tx_data = 8'hC3;
    for (int k = 2; k <= 41; k++) tick();
    chk("gap_rdy",  0, rdy[0], 1'b1);
    chk("gap_data", 0, udt[0], 1'b1);
    chk("gap_clk",  0, ucl[0], 1'b0);
    tick();
    chk("b2b_busy",  0, bsy[0], 1'b1);
    chk("b2b_start", 0, udt[0], 1'b0);
    tx_valid = 1'b0;

    // Valid pulse while busy must be dropped
    send(8'h5A);
    repeat (8) tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    wait_all_ready();
    tick();
    tick();
    chk("no_ff_frame", 0, bsy[0], 1'b0);

    // Reset during the fourth data bit, while usrt_clk is high
    send(8'hC6);
    for (int k = 2; k <= 19; k++) tick();
    chk("pre_rst_clk", 0, ucl[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data",  0, udt[0], 1'b1);
    chk("arst_clk",   0, ucl[0], 1'b0);
    chk("arst_busy",  0, bsy[0], 1'b0);
    chk("arst_ready", 0, rdy[0], 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_ready_low", 0, rdy[0], 1'b0);
    tick();
    chk("rel_ready", 0, rdy[0], 1'b1);

    // Randomized traffic with occasional data churn and rare resets
    for (int n = 0; n < 3000; n++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) tx_data = 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    tx_valid = 1'b0;
    wait_all_ready();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
